// File: rtl/clk_gate_ctrl.sv
// rtl/clk_gate_ctrl.sv - multi-channel idle-timeout clock gating controller
module clk_gate_ctrl #(
    parameter int NUM_CH     = 4,
    parameter int IDLE_CNT_W = 4,
    parameter int WAKE_DLY   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_CH-1:0]     ch_req,
    input  logic [NUM_CH-1:0]     ch_busy,
    input  logic                  force_on,
    input  logic [IDLE_CNT_W-1:0] idle_limit,
    output logic [NUM_CH-1:0]     gated_clk,
    output logic [NUM_CH-1:0]     ch_ack,
    output logic [NUM_CH-1:0]     ch_off
);

    localparam int WAKE_W = $clog2(WAKE_DLY + 1);
    localparam logic [WAKE_W-1:0] WAKE_END = WAKE_W'(WAKE_DLY);

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_WAKE = 2'd1,
        S_ON   = 2'd2,
        S_IDLE = 2'd3
    } state_t;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t                  state;
        logic [WAKE_W-1:0]       wake_cnt;
        logic [IDLE_CNT_W-1:0]   idle_cnt;
        logic                    en_q;
        logic                    ack_q;
        logic                    off_q;
        logic                    gate_lat;
        logic                    act;

        assign act = ch_req[i] | ch_busy[i];

        // Channel FSM; enable, ack and off are registered from the state being entered
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state    <= S_OFF;
                wake_cnt <= '0;
                idle_cnt <= '0;
                en_q     <= 1'b0;
                ack_q    <= 1'b0;
                off_q    <= 1'b1;
            end else begin
                case (state)
                    S_OFF: begin
                        if (act) begin
                            state    <= S_WAKE;
                            wake_cnt <= WAKE_W'(1);
                            en_q     <= 1'b1;
                            off_q    <= 1'b0;
                        end else begin
                            en_q <= force_on;
                        end
                    end
                    S_WAKE: begin
                        // A dropped request does not abort wake-up; ON handles it next
                        en_q <= 1'b1;
                        if (wake_cnt == WAKE_END) begin
                            state <= S_ON;
                            ack_q <= 1'b1;
                        end else begin
                            wake_cnt <= wake_cnt + WAKE_W'(1);
                        end
                    end
                    S_ON: begin
                        en_q <= 1'b1;
                        if (!act) begin
                            state    <= S_IDLE;
                            idle_cnt <= '0;
                        end
                    end
                    S_IDLE: begin
                        if (act) begin
                            state <= S_ON;
                            en_q  <= 1'b1;
                        end else if (idle_cnt >= idle_limit) begin
                            // >= so a limit lowered mid-idle still gates promptly
                            state <= S_OFF;
                            ack_q <= 1'b0;
                            off_q <= 1'b1;
                            en_q  <= force_on;
                        end else begin
                            idle_cnt <= idle_cnt + IDLE_CNT_W'(1);
                            en_q     <= 1'b1;
                        end
                    end
                    default: begin
                        state <= S_OFF;
                        en_q  <= force_on;
                        ack_q <= 1'b0;
                        off_q <= 1'b1;
                    end
                endcase
            end
        end

        // Gate latch: follows enable only while clk is low so the AND never chops a pulse
        always_latch begin
            if (!rst) begin
                gate_lat <= 1'b0;
            end else if (!clk) begin
                gate_lat <= en_q;
            end
        end

        assign gated_clk[i] = gate_lat & clk;
        assign ch_ack[i]    = ack_q;
        assign ch_off[i]    = off_q;
    end

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// tb/tb_clk_gate_ctrl.sv - self-checking bench for clk_gate_ctrl
module tb_clk_gate_ctrl;

    localparam int NUM_CH     = 4;
    localparam int IDLE_CNT_W = 4;
    localparam int WAKE_DLY   = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] ch_req;
    logic [3:0] ch_busy;
    logic       force_on;
    logic [3:0] idle_limit;
    logic [3:0] gated_clk;
    logic [3:0] ch_ack;
    logic [3:0] ch_off;

    always #5 clk = ~clk;

    clk_gate_ctrl #(
        .NUM_CH     (NUM_CH),
        .IDLE_CNT_W (IDLE_CNT_W),
        .WAKE_DLY   (WAKE_DLY)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ch_req     (ch_req),
        .ch_busy    (ch_busy),
        .force_on   (force_on),
        .idle_limit (idle_limit),
        .gated_clk  (gated_clk),
        .ch_ack     (ch_ack),
        .ch_off     (ch_off)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: a channel is off, or was woken at some edge; once awake for
    // WAKE_DLY edges it acknowledges, and it gates after more than limit+1
    // consecutive inactive samples.
    bit         m_off    [NUM_CH];
    int         woke_at  [NUM_CH];
    int         idle_run [NUM_CH];
    int         edge_n;
    logic [3:0] exp_en;
    logic [3:0] exp_ack;
    logic [3:0] exp_off;
    logic [3:0] g_at_edge;

    typedef struct {
        logic [3:0] req;
        logic [3:0] busy;
        logic       frc;
        logic [3:0] lim;
        logic [3:0] g;
        logic [3:0] ack;
        logic [3:0] off;
    } vec_t;

    vec_t tbl [23];

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        edge_n  = 0;
        exp_en  = 4'h0;
        exp_ack = 4'h0;
        exp_off = 4'hF;
        for (int i = 0; i < NUM_CH; i++) begin
            m_off[i]    = 1'b1;
            woke_at[i]  = 0;
            idle_run[i] = 0;
        end
    endfunction

    function automatic void model_edge(input logic [3:0] req, input logic [3:0] busy,
                                       input logic frc, input logic [3:0] lim);
        edge_n++;
        for (int i = 0; i < NUM_CH; i++) begin
            bit a;
            a = req[i] | busy[i];
            if (m_off[i]) begin
                if (a) begin
                    m_off[i]    = 1'b0;
                    woke_at[i]  = edge_n;
                    idle_run[i] = 0;
                end
            end else if (edge_n - woke_at[i] > WAKE_DLY) begin
                if (a) begin
                    idle_run[i] = 0;
                end else begin
                    idle_run[i]++;
                    if (idle_run[i] >= int'(lim) + 2) m_off[i] = 1'b1;
                end
            end
            exp_ack[i] = !m_off[i] && (edge_n - woke_at[i] >= WAKE_DLY);
            exp_off[i] = m_off[i];
            exp_en[i]  = !m_off[i] || frc;
        end
    endfunction

    task automatic do_cycle(input logic [3:0] req, input logic [3:0] busy,
                            input logic frc, input logic [3:0] lim);
        ch_req     = req;
        ch_busy    = busy;
        force_on   = frc;
        idle_limit = lim;
        @(posedge clk);
        #1;
        g_at_edge = gated_clk;
        chk("gated_hi", gated_clk, exp_en);
        model_edge(req, busy, frc, lim);
        chk("ack", ch_ack, exp_ack);
        chk("off", ch_off, exp_off);
        @(negedge clk);
        #1;
        chk("gated_lo", gated_clk, 4'h0);
    endtask

    logic [3:0]  want;
    logic [31:0] r;
    logic        rfrc;
    logic [3:0]  rlim;

    initial begin
        tbl[0]  = '{4'h0, 4'h0, 1'b0, 4'd3, 4'h0, 4'h0, 4'hF};
        tbl[1]  = '{4'h1, 4'h0, 1'b0, 4'd3, 4'h0, 4'h0, 4'hE};
        tbl[2]  = '{4'h1, 4'h0, 1'b0, 4'd3, 4'h1, 4'h0, 4'hE};
        tbl[3]  = '{4'h1, 4'h0, 1'b0, 4'd3, 4'h1, 4'h1, 4'hE};
        tbl[4]  = '{4'h0, 4'h0, 1'b0, 4'd3, 4'h1, 4'h1, 4'hE};
        tbl[5]  = '{4'h0, 4'h0, 1'b0, 4'd3, 4'h1, 4'h1, 4'hE};
        tbl[6]  = '{4'h0, 4'h0, 1'b0, 4'd3, 4'h1, 4'h1, 4'hE};
        tbl[7]  = '{4'h0, 4'h0, 1'b0, 4'd3, 4'h1, 4'h1, 4'hE};
        tbl[8]  = '{4'h0, 4'h0, 1'b0, 4'd3, 4'h1, 4'h0, 4'hF};
        tbl[9]  = '{4'h0, 4'h0, 1'b0, 4'd3, 4'h0, 4'h0, 4'hF};
        tbl[10] = '{4'h0, 4'h1, 1'b0, 4'd3, 4'h0, 4'h0, 4'hE};
        tbl[11] = '{4'h0, 4'h0, 1'b0, 4'd3, 4'h1, 4'h0, 4'hE};
        tbl[12] = '{4'h0, 4'h0, 1'b0, 4'd3, 4'h1, 4'h1, 4'hE};
        tbl[13] = '{4'h0, 4'h0, 1'b0, 4'd3, 4'h1, 4'h1, 4'hE};
        tbl[14] = '{4'h1, 4'h0, 1'b0, 4'd3, 4'h1, 4'h1, 4'hE};
        tbl[15] = '{4'h1, 4'h0, 1'b0, 4'd3, 4'h1, 4'h1, 4'hE};
        tbl[16] = '{4'h0, 4'h0, 1'b0, 4'd0, 4'h1, 4'h1, 4'hE};
        tbl[17] = '{4'h0, 4'h0, 1'b0, 4'd0, 4'h1, 4'h0, 4'hF};
        tbl[18] = '{4'h0, 4'h0, 1'b0, 4'd0, 4'h0, 4'h0, 4'hF};
        tbl[19] = '{4'h0, 4'h0, 1'b1, 4'd3, 4'h0, 4'h0, 4'hF};
        tbl[20] = '{4'h0, 4'h0, 1'b1, 4'd3, 4'hF, 4'h0, 4'hF};
        tbl[21] = '{4'h0, 4'h0, 1'b0, 4'd3, 4'hF, 4'h0, 4'hF};
        tbl[22] = '{4'h0, 4'h0, 1'b0, 4'd3, 4'h0, 4'h0, 4'hF};

        rst        = 1'b0;
        ch_req     = 4'h0;
        ch_busy    = 4'h0;
        force_on   = 1'b0;
        idle_limit = 4'd3;
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_gated", gated_clk, 4'h0);
        chk("rst_ack", ch_ack, 4'h0);
        chk("rst_off", ch_off, 4'hF);
        rst = 1'b1;

        // Quiet after reset
        for (int n = 0; n < 20; n++) do_cycle(4'h0, 4'h0, 1'b0, 4'd3);

        // Directed vectors: wake latency, idle timeout, busy wake, limit 0, force
        for (int v = 0; v < 23; v++) begin
            do_cycle(tbl[v].req, tbl[v].busy, tbl[v].frc, tbl[v].lim);
            chk($sformatf("tbl%0d_g", v), g_at_edge, tbl[v].g);
            chk($sformatf("tbl%0d_ack", v), ch_ack, tbl[v].ack);
            chk($sformatf("tbl%0d_off", v), ch_off, tbl[v].off);
        end

        // Short busy dip on channel 2 with a long limit keeps it acknowledged
        repeat (3) do_cycle(4'h0, 4'h4, 1'b0, 4'd5);
        repeat (2) begin
            do_cycle(4'h0, 4'h0, 1'b0, 4'd5);
            chk("dip_ack2", {3'b000, ch_ack[2]}, 4'h1);
            chk("dip_g2", {3'b000, g_at_edge[2]}, 4'h1);
        end
        repeat (3) begin
            do_cycle(4'h0, 4'h4, 1'b0, 4'd5);
            chk("dip_ack2", {3'b000, ch_ack[2]}, 4'h1);
            chk("dip_g2", {3'b000, g_at_edge[2]}, 4'h1);
        end
        repeat (10) do_cycle(4'h0, 4'h0, 1'b0, 4'd2);

        // Randomised traffic against the model
        want = 4'h0;
        rfrc = 1'b0;
        rlim = 4'd3;
        for (int n = 0; n < 1500; n++) begin
            r = $urandom;
            for (int i = 0; i < NUM_CH; i++) begin
                if ($urandom_range(0, 7) == 0) want[i] = ~want[i];
            end
            if ($urandom_range(0, 29) == 0) rfrc = ~rfrc;
            if ($urandom_range(0, 39) == 0) rlim = 4'($urandom_range(0, 5));
            do_cycle(want & r[3:0],
                     (want & ~r[3:0]) | (~want & r[7:4] & r[11:8] & r[15:12]),
                     rfrc, rlim);
        end

        // All channels on, then reset while the gated clocks are high
        repeat (WAKE_DLY + 3) do_cycle(4'hF, 4'h0, 1'b0, 4'd3);
        chk("pre_rst_ack", ch_ack, 4'hF);
        ch_req = 4'hF;
        @(posedge clk);
        #2;
        chk("pre_rst_gated", gated_clk, 4'hF);
        rst = 1'b0;
        #1;
        chk("mid_rst_gated", gated_clk, 4'h0);
        chk("mid_rst_ack", ch_ack, 4'h0);
        chk("mid_rst_off", ch_off, 4'hF);
        model_reset();
        @(negedge clk);
        #1;
        chk("rst_low_gated", gated_clk, 4'h0);
        rst = 1'b1;
        repeat (4) do_cycle(4'h0, 4'h0, 1'b0, 4'd3);
        repeat (WAKE_DLY + 2) do_cycle(4'h8, 4'h0, 1'b0, 4'd3);
        chk("rewake_ack", ch_ack, 4'h8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
